// File: rtl/non_restoring_divider_pkg.sv
// Shared definitions for the non-restoring divider: FSM encoding, default width
// and the iteration-counter width helper.
package non_restoring_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam int DEFAULT_N = 4;

    // Counter must hold the value N itself, hence N+1 codes.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_N);

endpackage

// File: rtl/non_restoring_divider_addsub_step.sv
// One combinational non-restoring iteration: shift {A,Qw} left, add or subtract M
// depending on the old sign of A, and shift the new quotient bit into Qw.
module nr_addsub_step
    import non_restoring_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N:0]   i_a,
    input  logic [N-1:0] i_qw,
    input  logic [N:0]   i_m,
    output logic [N:0]   o_a,
    output logic [N-1:0] o_qw
);

    logic [N:0] w_a_sh;
    logic [N:0] w_a_new;

    assign w_a_sh = {i_a[N-1:0], i_qw[N-1]};

    // Sign of the partial remainder before the shift selects subtract or add.
    always_comb begin
        w_a_new = w_a_sh;
        if (i_a[N] == 1'b0) begin
            w_a_new = w_a_sh - i_m;
        end else begin
            w_a_new = w_a_sh + i_m;
        end
    end

    assign o_a  = w_a_new;
    assign o_qw = {i_qw[N-2:0], ~w_a_new[N]};

endmodule

// File: rtl/non_restoring_divider.sv
// Sequential unsigned divider (non-restoring), one quotient bit per clock,
// with a start/busy/done handshake and a final remainder-correction state.
module non_restoring_divider
    import non_restoring_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N:0]   R,
    output logic [N-1:0] Q
);

    localparam int CNT_W = cnt_width(N);

    state_t             r_state;
    state_t             w_state_next;
    logic [N:0]         r_a;
    logic [N:0]         w_a_next;
    logic [N-1:0]       r_qw;
    logic [N-1:0]       w_qw_next;
    logic [N:0]         r_m;
    logic [N:0]         w_m_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_busy;
    logic               w_busy_next;
    logic               r_done;
    logic               w_done_next;
    logic               r_dbz;
    logic               w_dbz_next;
    logic [N:0]         r_r;
    logic [N:0]         w_r_next;
    logic [N-1:0]       r_q;
    logic [N-1:0]       w_q_next;
    logic [N:0]         w_step_a;
    logic [N-1:0]       w_step_qw;
    logic [N:0]         w_fix_a;

    nr_addsub_step #(.N(N)) u_step (
        .i_a  (r_a),
        .i_qw (r_qw),
        .i_m  (r_m),
        .o_a  (w_step_a),
        .o_qw (w_step_qw)
    );

    // A negative final partial remainder is pulled back into [0, M).
    assign w_fix_a = r_a[N] ? (r_a + r_m) : r_a;

    // Next-state, datapath and output-register logic.
    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_qw_next    = r_qw;
        w_m_next     = r_m;
        w_cnt_next   = r_cnt;
        w_r_next     = r_r;
        w_q_next     = r_q;
        w_dbz_next   = r_dbz;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_ITER;
                    w_a_next     = '0;
                    w_qw_next    = X;
                    w_m_next     = {1'b0, Y};
                    w_cnt_next   = CNT_W'(N);
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ITER: begin
                w_a_next   = w_step_a;
                w_qw_next  = w_step_qw;
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = ST_FIX;
                end else begin
                    w_state_next = ST_ITER;
                end
            end
            ST_FIX: begin
                w_a_next     = w_fix_a;
                w_r_next     = w_fix_a;
                w_q_next     = r_qw;
                w_dbz_next   = (r_m == '0);
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_busy_next = (w_state_next != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_qw   <= '0;
            r_m    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            r_r    <= '0;
            r_q    <= '0;
        end else begin
            r_a    <= w_a_next;
            r_qw   <= w_qw_next;
            r_m    <= w_m_next;
            r_cnt  <= w_cnt_next;
            r_busy <= w_busy_next;
            r_done <= w_done_next;
            r_dbz  <= w_dbz_next;
            r_r    <= w_r_next;
            r_q    <= w_q_next;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign R           = r_r;
    assign Q           = r_q;

endmodule

// File: tb/tb_non_restoring_divider.sv
// Self-checking bench for non_restoring_divider (N=4) using an expected-result
// queue filled at stimulus time and drained when done pulses.
module tb_non_restoring_divider;

    localparam int N       = 4;
    localparam int EXP_LAT = N + 2;
    localparam int MAX_LAT = 20;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N:0]   r;
        logic         dbz;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [N:0]   R;
    logic [N-1:0] Q;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    non_restoring_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .X           (X),
        .Y           (Y),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .R           (R),
        .Q           (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        if (y == 4'd0) begin
            e.q   = 4'hF;
            e.r   = {1'b0, x};
            e.dbz = 1'b1;
        end else begin
            e.q   = x / y;
            e.r   = {1'b0, x % y};
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Drives one request, pushes its expectation, waits (bounded) for done.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          output logic [N-1:0] q, output logic [N:0] r,
                          output logic z, output logic b, output int lat);
        @(negedge clk);
        X = x; Y = y; start = 1'b1;
        sb.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
        end
        q = Q; r = R; z = div_by_zero; b = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; X = 4'd0; Y = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, done, div_by_zero, R, Q} !== {1'b0, 1'b0, 1'b0, 5'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b R=%b Q=%b, need all 0",
                     busy, done, div_by_zero, R, Q);
        end
    endtask

    task automatic test_vectors();
        logic [N-1:0] xs [8] = '{4'd1, 4'd6, 4'd12, 4'd13, 4'd14, 4'd5, 4'd9, 4'd11};
        logic [N-1:0] ys [8] = '{4'd1, 4'd2, 4'd3, 4'd12, 4'd9, 4'd10, 4'd12, 4'd0};
        logic [N-1:0] q;
        logic [N:0]   r;
        logic         z;
        logic         b;
        int           lat;
        exp_t         e;
        for (int i = 0; i < 8; i++) begin
            run_op(xs[i], ys[i], q, r, z, b, lat);
            e = sb.pop_front();
            n_tests++;
            if ({q, r, z} !== {e.q, e.r, e.dbz}) begin
                n_fail++;
                $display("FAIL vector_%0d X=%0d Y=%0d: Q=%b R=%b dbz=%b, need Q=%b R=%b dbz=%b",
                         i, xs[i], ys[i], q, r, z, e.q, e.r, e.dbz);
            end
            n_tests++;
            if (lat !== EXP_LAT) begin
                n_fail++;
                $display("FAIL latency_%0d: got %0d edges, need %0d", i, lat, EXP_LAT);
            end
            n_tests++;
            if (b !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_with_done_%0d: busy=%b, need 0", i, b);
            end
            @(negedge clk);
            n_tests++;
            if ({done, Q, R, div_by_zero} !== {1'b0, e.q, e.r, e.dbz}) begin
                n_fail++;
                $display("FAIL hold_%0d: done=%b Q=%b R=%b dbz=%b, need done=0 Q=%b R=%b dbz=%b",
                         i, done, Q, R, div_by_zero, e.q, e.r, e.dbz);
            end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int   lat;
        int   extra;
        @(negedge clk);
        X = 4'd7; Y = 4'd2; start = 1'b1;
        sb.push_back(model(4'd7, 4'd2));
        @(negedge clk);
        start = 1'b0; lat = 1;
        @(negedge clk);
        lat++;
        X = 4'd15; Y = 4'd1; start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        n_tests++;
        if ({Q, R, lat} !== {e.q, e.r, EXP_LAT}) begin
            n_fail++;
            $display("FAIL busy_ignore: Q=%b R=%b lat=%0d, need Q=%b R=%b lat=%0d",
                     Q, R, lat, e.q, e.r, EXP_LAT);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL no_queuing: %0d busy/done cycles after ignored start, need 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] q;
        logic [N:0]   r;
        logic         z;
        logic         b;
        int           lat;
        exp_t         e1;
        exp_t         e2;
        run_op(4'd9, 4'd4, q, r, z, b, lat);
        e1 = sb.pop_front();
        n_tests++;
        if ({q, r, lat} !== {e1.q, e1.r, EXP_LAT}) begin
            n_fail++;
            $display("FAIL b2b_first: Q=%b R=%b lat=%0d, need Q=%b R=%b lat=%0d",
                     q, r, lat, e1.q, e1.r, EXP_LAT);
        end
        X = 4'd14; Y = 4'd3; start = 1'b1;
        sb.push_back(model(4'd14, 4'd3));
        @(negedge clk);
        start = 1'b0; lat = 1;
        n_tests++;
        if ({busy, done, Q, R} !== {1'b1, 1'b0, e1.q, e1.r}) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b Q=%b R=%b, need busy=1 done=0 Q=%b R=%b",
                     busy, done, Q, R, e1.q, e1.r);
        end
        while (done !== 1'b1 && lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
        end
        e2 = sb.pop_front();
        n_tests++;
        if ({Q, R, lat} !== {e2.q, e2.r, EXP_LAT}) begin
            n_fail++;
            $display("FAIL b2b_second: Q=%b R=%b lat=%0d, need Q=%b R=%b lat=%0d",
                     Q, R, lat, e2.q, e2.r, EXP_LAT);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        X = 4'd13; Y = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({busy, done, div_by_zero, R, Q} !== {1'b0, 1'b0, 1'b0, 5'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b dbz=%b R=%b Q=%b, need all 0",
                     busy, done, div_by_zero, R, Q);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: %0d busy/done cycles after abort, need 0", seen);
        end
    endtask

    task automatic test_exhaustive();
        logic [N-1:0] q;
        logic [N:0]   r;
        logic         z;
        logic         b;
        int           lat;
        exp_t         e;
        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 16; y++) begin
                run_op(x[N-1:0], y[N-1:0], q, r, z, b, lat);
                e = sb.pop_front();
                n_tests++;
                if ({q, r, z, lat} !== {e.q, e.r, e.dbz, EXP_LAT}) begin
                    n_fail++;
                    $display("FAIL exhaustive X=%0d Y=%0d: Q=%0d R=%0d dbz=%b lat=%0d, need Q=%0d R=%0d dbz=%b lat=%0d",
                             x, y, q, r, z, lat, e.q, e.r, e.dbz, EXP_LAT);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_vectors();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        n_tests++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
